// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with an anti-ghosting blank
// interval at the start of every digit slot and 16-step PWM brightness.

// Per-digit enable: a registered select bit for one digit position.
module seg7_scan_lane #(
  parameter int IDX        = 0,
  parameter int DW         = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lit,
  input  logic [DW-1:0] digit,
  output logic          sel
);
  localparam logic POL = (ACTIVE_LOW != 0);

  // Drive this digit only while the shared pattern belongs to it.
  always_ff @(posedge clk) begin
    if (reset) sel <= POL;
    else       sel <= (lit && digit == DW'(IDX)) ? ~POL : POL;
  end
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic          POL        = (ACTIVE_LOW != 0);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  logic [NUM_DIGITS-1:0][6:0] pat_in;
  assign pat_in = seg_in;

  state_t        state, state_n;
  logic [SW-1:0] slot_cnt, slot_n;
  logic [DW-1:0] digit, digit_n, latch_idx;
  logic [3:0]    pwm_cnt, pwm_n;
  logic [6:0]    pattern;
  logic          latch_en, wrap, lit;
  logic [1:0]    tick_pipe;

  // Next-state: slot counter walks blank then on; digit advances at slot end.
  always_comb begin
    state_n   = state;
    slot_n    = slot_cnt;
    digit_n   = digit;
    pwm_n     = pwm_cnt;
    latch_en  = 1'b0;
    latch_idx = digit;
    wrap      = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      slot_n  = '0;
      digit_n = '0;
      pwm_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = BLANK;
          slot_n    = '0;
          digit_n   = '0;
          latch_en  = 1'b1;
          latch_idx = '0;
        end
        BLANK: begin
          slot_n = slot_cnt + SW'(1);
          if (slot_cnt == BLANK_LAST) begin
            state_n = ON;
            pwm_n   = '0;
          end
        end
        ON: begin
          if (slot_cnt == SCAN_LAST) begin
            state_n   = BLANK;
            slot_n    = '0;
            digit_n   = (digit == DIG_LAST) ? '0 : digit + DW'(1);
            latch_en  = 1'b1;
            latch_idx = digit_n;
            wrap      = (digit == DIG_LAST);
          end else begin
            slot_n = slot_cnt + SW'(1);
            pwm_n  = pwm_cnt + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counters and the pattern latched as each slot begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      slot_cnt <= '0;
      digit    <= '0;
      pwm_cnt  <= '0;
      pattern  <= '0;
    end else begin
      state    <= state_n;
      slot_cnt <= slot_n;
      digit    <= digit_n;
      pwm_cnt  <= pwm_n;
      if (latch_en) pattern <= pat_in[latch_idx];
    end
  end

  // Brightness is taken live; 15 bypasses the PWM compare for full duty.
  assign lit = (state == ON) && (brightness == 4'hF || pwm_cnt < brightness);

  // Segment drive registered from the same state as the digit enables.
  always_ff @(posedge clk) begin
    if (reset) seg_out <= {7{POL}};
    else       seg_out <= lit ? (pattern ^ {7{POL}}) : {7{POL}};
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
      seg7_scan_lane #(.IDX(g), .DW(DW), .ACTIVE_LOW(ACTIVE_LOW)) u_lane (
        .clk   (clk),
        .reset (reset),
        .lit   (lit),
        .digit (digit),
        .sel   (dig_sel[g])
      );
    end
  endgenerate

  // Wrap is seen one edge before digit 0's blank state exists; the second
  // stage lines the tick up with that state's registered output cycle.
  always_ff @(posedge clk) begin
    if (reset) tick_pipe <= '0;
    else       tick_pipe <= {tick_pipe[0], wrap};
  end
  assign frame_tick = tick_pipe[1];
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: timeline reference model plus directed checks.
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int S = 20;
  localparam int B = 4;
  localparam int FRAME = N * S;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [27:0] seg_in = '0;
  logic [3:0]  brightness = 4'hF;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .seg_in     (seg_in),
    .brightness (brightness),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  // Reference: m_t = cycles since the scan started; position, digit and PWM
  // phase follow from plain division. Expected outputs lag that by one edge.
  logic       m_run = 1'b0;
  int         m_t = 0;
  logic [6:0] m_pat = '0;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_dig = 4'hF;
  logic       e_tick = 1'b0;
  int         pos, dg, nd;
  logic       m_lit;
  logic [3:0] one4 = 4'b0001;

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 1'b0; m_t <= 0; m_pat <= '0;
      e_seg <= 7'h7F; e_dig <= 4'hF; e_tick <= 1'b0;
    end else begin
      pos   = m_t % S;
      dg    = (m_t / S) % N;
      m_lit = m_run && pos >= B && (brightness == 4'hF || ((pos - B) % 16) < int'(brightness));
      e_seg  <= m_lit ? ~m_pat : 7'h7F;
      e_dig  <= m_lit ? ~(one4 << dg) : 4'hF;
      e_tick <= m_run && m_t > 0 && (m_t % FRAME) == 0;
      if (!enable) begin
        m_run <= 1'b0; m_t <= 0;
      end else if (!m_run) begin
        m_run <= 1'b1; m_t <= 0; m_pat <= seg_in[6:0];
      end else begin
        m_t <= m_t + 1;
        if (((m_t + 1) % S) == 0) begin
          nd = ((m_t + 1) / S) % N;
          m_pat <= seg_in[7*nd +: 7];
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int lit_cnt = 0;
  int tick_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("seg_out", int'(seg_out), int'(e_seg));
    chk("dig_sel", int'(dig_sel), int'(e_dig));
    chk("frame_tick", int'(frame_tick), int'(e_tick));
    if (dig_sel != 4'hF) lit_cnt++;
    if (frame_tick) tick_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance until the reference timeline sits at the given frame phase.
  task automatic wait_phase(input int ph, input string tag);
    int k = 0;
    while (!(m_run && (m_t % FRAME) == ph)) begin
      step();
      k++;
      if (k > 4 * FRAME) begin
        tests++; fails++;
        $error("FAIL %s: phase %0d not reached, got t=%0d", tag, ph, m_t);
        break;
      end
    end
  endtask

  task automatic window(input int lit_exp, input int tick_exp, input string tag);
    lit_cnt = 0; tick_cnt = 0;
    run(FRAME);
    chk({tag, "_lit"}, lit_cnt, lit_exp);
    chk({tag, "_tick"}, tick_cnt, tick_exp);
  endtask

  initial begin
    seg_in = {7'h06, 7'h5B, 7'h4F, 7'h3F};
    // Reset held three cycles with enable already high.
    run(3);
    chk("rst_seg", int'(seg_out), 'h7F);
    chk("rst_dig", int'(dig_sel), 'hF);
    reset = 1'b0;
    for (int i = 0; i < B + 1; i++) begin
      step();
      chk("start_seg", int'(seg_out), 'h7F);
      chk("start_dig", int'(dig_sel), 'hF);
    end
    step();
    chk("first_seg", int'(seg_out), 'h40);
    chk("first_dig", int'(dig_sel), 'hE);
    run(S - 1);
    chk("d1_seg_blank", int'(seg_out), 'h7F);
    run(B);
    chk("d1_seg", int'(seg_out), 'h30);
    chk("d1_dig", int'(dig_sel), 'hD);

    // Full-frame windows at several brightness levels.
    window(64, 1, "br15");
    brightness = 4'd4;
    window(16, 1, "br4");
    brightness = 4'd0;
    window(0, 1, "br0");
    brightness = 4'd9;
    window(36, 1, "br9");
    brightness = 4'd1;
    window(4, 1, "br1");

    // Mid-slot pattern change on digit 0 is held off until its next slot.
    brightness = 4'hF;
    wait_phase(10, "chg_phase");
    seg_in[6:0] = 7'h06;
    step();
    chk("hold_seg", int'(seg_out), 'h40);
    run(S - 10);
    wait_phase(B + 1, "next_d0");
    step();
    chk("new_seg", int'(seg_out), 'h79);

    // Enable drop during digit 2 ON, then restart from digit 0.
    wait_phase(2 * S + 8, "d2_phase");
    enable = 1'b0;
    run(2);
    chk("drop_dig", int'(dig_sel), 'hF);
    chk("drop_seg", int'(seg_out), 'h7F);
    run(3);
    enable = 1'b1;
    run(B + 1);
    chk("re_dark", int'(dig_sel), 'hF);
    step();
    chk("re_dig", int'(dig_sel), 'hE);
    tick_cnt = 0;
    run(FRAME - 10);
    chk("re_notick", tick_cnt, 0);

    // One-cycle reset mid-slot on digit 3.
    wait_phase(3 * S + 9, "d3_phase");
    reset = 1'b1;
    step();
    chk("mr_dig", int'(dig_sel), 'hF);
    chk("mr_tick", int'(frame_tick), 0);
    reset = 1'b0;
    run(B + 1);
    chk("mr_dark", int'(dig_sel), 'hF);
    step();
    chk("mr_dig0", int'(dig_sel), 'hE);
    chk("mr_seg0", int'(seg_out), 'h79);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      seg_in     = {$urandom, $urandom} & 28'hFFF_FFFF;
      brightness = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0: enable = ~enable;
        1: begin reset = 1'b1; step(); reset = 1'b0; end
        default: enable = 1'b1;
      endcase
      run($urandom_range(1, 60));
    end
    enable = 1'b1;
    run(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
